// File: rtl/register_pkg.sv
// rtl/register_pkg.sv - op-select encoding and priority encoder for register_nb
package register_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_CL   = 3'd1,
        OP_LD   = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4,
        OP_SHR  = 3'd5,
        OP_SHL  = 3'd6
    } op_t;

    // Highest-priority asserted control wins; all lower ones are ignored.
    function automatic op_t op_select(
        input logic cl,
        input logic ld,
        input logic inc,
        input logic dec,
        input logic shr,
        input logic shl
    );
        if (cl)       return OP_CL;
        else if (ld)  return OP_LD;
        else if (inc) return OP_INC;
        else if (dec) return OP_DEC;
        else if (shr) return OP_SHR;
        else if (shl) return OP_SHL;
        else          return OP_NONE;
    endfunction

endpackage

// File: rtl/register_nb_next.sv
// rtl/register_nb_next.sv - combinational next-value and overflow logic
module register_nb_next
    import register_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit SATURATE   = 1'b0
) (
    input  op_t                   op,
    input  logic [DATA_WIDTH-1:0] out,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  ir,
    input  logic                  il,
    output logic [DATA_WIDTH-1:0] next_val,
    output logic                  ovf_next
);

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        next_val = out;
        ovf_next = 1'b0;
        case (op)
            OP_CL:  next_val = '0;
            OP_LD:  next_val = in;
            OP_INC: begin
                // At all-ones: wrap to zero or clamp, flagging overflow either way.
                if (&out) begin
                    ovf_next = 1'b1;
                    next_val = SATURATE ? out : '0;
                end else begin
                    next_val = out + ONE;
                end
            end
            OP_DEC: begin
                if (out == '0) begin
                    ovf_next = 1'b1;
                    next_val = SATURATE ? out : '1;
                end else begin
                    next_val = out - ONE;
                end
            end
            OP_SHR: next_val = {ir, out[DATA_WIDTH-1:1]};
            OP_SHL: next_val = {out[DATA_WIDTH-2:0], il};
            default: next_val = out;
        endcase
    end

endmodule

// File: rtl/register_nb.sv
// rtl/register_nb.sv - parametrised load/count/shift register with overflow pulse
module register_nb
    import register_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter bit                    SATURATE    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cl,
    input  logic                  ld,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  shr,
    input  logic                  ir,
    input  logic                  shl,
    input  logic                  il,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  zero,
    output logic                  ovf
);

    op_t                   op;
    logic [DATA_WIDTH-1:0] next_val;
    logic                  ovf_next;

    assign op = op_select(cl, ld, inc, dec, shr, shl);

    register_nb_next #(
        .DATA_WIDTH (DATA_WIDTH),
        .SATURATE   (SATURATE)
    ) u_next (
        .op       (op),
        .out      (out),
        .in       (in),
        .ir       (ir),
        .il       (il),
        .next_val (next_val),
        .ovf_next (ovf_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= RESET_VALUE;
            ovf <= 1'b0;
        end else begin
            out <= next_val;
            ovf <= ovf_next;
        end
    end

    assign zero = (out == '0);

endmodule

// File: tb/tb_register_nb.sv
// tb/tb_register_nb.sv - directed self-checking bench for register_nb
module tb_register_nb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cl, ld, inc, dec, shr, ir, shl, il;
    logic [7:0]  in8;
    logic [15:0] in16;

    logic [7:0]  out_a, out_s;
    logic [15:0] out_w;
    logic        zero_a, zero_s, zero_w;
    logic        ovf_a, ovf_s, ovf_w;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    register_nb #(.DATA_WIDTH(8), .RESET_VALUE(8'h5A), .SATURATE(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .inc(inc), .dec(dec),
        .shr(shr), .ir(ir), .shl(shl), .il(il), .in(in8),
        .out(out_a), .zero(zero_a), .ovf(ovf_a)
    );

    register_nb #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .inc(inc), .dec(dec),
        .shr(shr), .ir(ir), .shl(shl), .il(il), .in(in8),
        .out(out_s), .zero(zero_s), .ovf(ovf_s)
    );

    register_nb #(.DATA_WIDTH(16), .RESET_VALUE(16'h0000), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .inc(inc), .dec(dec),
        .shr(shr), .ir(ir), .shl(shl), .il(il), .in(in16),
        .out(out_w), .zero(zero_w), .ovf(ovf_w)
    );

    task automatic idle_ctrl();
        cl = 0; ld = 0; inc = 0; dec = 0; shr = 0; ir = 0; shl = 0; il = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_ctrl();
        rst_n = 1'b0;
        ld = 1; in8 = 8'hC3; in16 = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (out_a !== 8'h5A) $display("FAIL reset_out: got %h expected %h", out_a, 8'h5A);
        else pass_cnt++;
        total_cnt++;
        if (zero_a !== 1'b0) $display("FAIL reset_zero: got %b expected %b", zero_a, 1'b0);
        else pass_cnt++;
        total_cnt++;
        if (ovf_a !== 1'b0) $display("FAIL reset_ovf: got %b expected %b", ovf_a, 1'b0);
        else pass_cnt++;
        total_cnt++;
        if (zero_s !== 1'b1) $display("FAIL reset_zero_rv0: got %b expected %b", zero_s, 1'b1);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (out_a !== 8'hC3) $display("FAIL load_after_reset: got %h expected %h", out_a, 8'hC3);
        else pass_cnt++;
        idle_ctrl();
    endtask

    task automatic test_priority();
        idle_ctrl();
        ld = 1; in8 = 8'h10;
        step();
        idle_ctrl();
        cl = 1; ld = 1; inc = 1; in8 = 8'h77;
        step();
        total_cnt++;
        if (out_a !== 8'h00) $display("FAIL prio_cl: got %h expected %h", out_a, 8'h00);
        else pass_cnt++;
        total_cnt++;
        if (zero_a !== 1'b1) $display("FAIL prio_cl_zero: got %b expected %b", zero_a, 1'b1);
        else pass_cnt++;
        idle_ctrl();
        ld = 1; inc = 1; in8 = 8'h22;
        step();
        total_cnt++;
        if (out_a !== 8'h22) $display("FAIL prio_ld: got %h expected %h", out_a, 8'h22);
        else pass_cnt++;
        idle_ctrl();
        inc = 1; dec = 1;
        step();
        total_cnt++;
        if (out_a !== 8'h23) $display("FAIL prio_inc_dec: got %h expected %h", out_a, 8'h23);
        else pass_cnt++;
        total_cnt++;
        if (ovf_a !== 1'b0) $display("FAIL prio_ovf: got %b expected %b", ovf_a, 1'b0);
        else pass_cnt++;
        idle_ctrl();
    endtask

    task automatic test_wrap();
        idle_ctrl();
        ld = 1; in8 = 8'hFF;
        step();
        idle_ctrl();
        inc = 1;
        step();
        total_cnt++;
        if (out_a !== 8'h00) $display("FAIL wrap_inc: got %h expected %h", out_a, 8'h00);
        else pass_cnt++;
        total_cnt++;
        if (ovf_a !== 1'b1) $display("FAIL wrap_inc_ovf: got %b expected %b", ovf_a, 1'b1);
        else pass_cnt++;
        idle_ctrl();
        dec = 1;
        step();
        total_cnt++;
        if (out_a !== 8'hFF) $display("FAIL wrap_dec: got %h expected %h", out_a, 8'hFF);
        else pass_cnt++;
        total_cnt++;
        if (ovf_a !== 1'b1) $display("FAIL wrap_dec_ovf: got %b expected %b", ovf_a, 1'b1);
        else pass_cnt++;
        idle_ctrl();
        step();
        total_cnt++;
        if (ovf_a !== 1'b0) $display("FAIL wrap_idle_ovf: got %b expected %b", ovf_a, 1'b0);
        else pass_cnt++;
        total_cnt++;
        if (out_a !== 8'hFF) $display("FAIL wrap_idle_hold: got %h expected %h", out_a, 8'hFF);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        idle_ctrl();
        ld = 1; in8 = 8'hFF;
        step();
        idle_ctrl();
        inc = 1;
        step();
        total_cnt++;
        if (out_s !== 8'hFF) $display("FAIL sat_inc: got %h expected %h", out_s, 8'hFF);
        else pass_cnt++;
        total_cnt++;
        if (ovf_s !== 1'b1) $display("FAIL sat_inc_ovf: got %b expected %b", ovf_s, 1'b1);
        else pass_cnt++;
        idle_ctrl();
        ld = 1; in8 = 8'h00;
        step();
        total_cnt++;
        if (ovf_s !== 1'b0) $display("FAIL sat_ld_ovf: got %b expected %b", ovf_s, 1'b0);
        else pass_cnt++;
        idle_ctrl();
        dec = 1;
        step();
        total_cnt++;
        if (out_s !== 8'h00) $display("FAIL sat_dec: got %h expected %h", out_s, 8'h00);
        else pass_cnt++;
        total_cnt++;
        if (ovf_s !== 1'b1) $display("FAIL sat_dec_ovf: got %b expected %b", ovf_s, 1'b1);
        else pass_cnt++;
        idle_ctrl();
    endtask

    task automatic test_shifts();
        idle_ctrl();
        ld = 1; in8 = 8'b1000_0001;
        step();
        idle_ctrl();
        shl = 1; il = 1;
        step();
        total_cnt++;
        if (out_a !== 8'b0000_0011) $display("FAIL shl_fill1: got %b expected %b", out_a, 8'b0000_0011);
        else pass_cnt++;
        idle_ctrl();
        shr = 1; ir = 1;
        step();
        total_cnt++;
        if (out_a !== 8'b1000_0001) $display("FAIL shr_fill1: got %b expected %b", out_a, 8'b1000_0001);
        else pass_cnt++;
        idle_ctrl();
        shr = 1; ir = 0;
        step();
        total_cnt++;
        if (out_a !== 8'b0100_0000) $display("FAIL shr_fill0: got %b expected %b", out_a, 8'b0100_0000);
        else pass_cnt++;
        total_cnt++;
        if (ovf_a !== 1'b0) $display("FAIL shift_ovf: got %b expected %b", ovf_a, 1'b0);
        else pass_cnt++;
        idle_ctrl();
    endtask

    task automatic test_async_reset();
        idle_ctrl();
        ld = 1; in16 = 16'hFFFF;
        step();
        idle_ctrl();
        inc = 1;
        step();
        total_cnt++;
        if (out_w !== 16'h0000) $display("FAIL w16_wrap: got %h expected %h", out_w, 16'h0000);
        else pass_cnt++;
        total_cnt++;
        if (ovf_w !== 1'b1) $display("FAIL w16_wrap_ovf: got %b expected %b", ovf_w, 1'b1);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (ovf_w !== 1'b0) $display("FAIL async_ovf_clear: got %b expected %b", ovf_w, 1'b0);
        else pass_cnt++;
        rst_n = 1'b1;
        idle_ctrl();
        ld = 1; in16 = 16'hFFFE;
        step();
        idle_ctrl();
        inc = 1;
        step();
        total_cnt++;
        if (out_w !== 16'hFFFF) $display("FAIL w16_count: got %h expected %h", out_w, 16'hFFFF);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_w !== 16'h0000) $display("FAIL async_out: got %h expected %h", out_w, 16'h0000);
        else pass_cnt++;
        total_cnt++;
        if (zero_w !== 1'b1) $display("FAIL async_zero: got %b expected %b", zero_w, 1'b1);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (out_w !== 16'h0001) $display("FAIL resume_count: got %h expected %h", out_w, 16'h0001);
        else pass_cnt++;
        total_cnt++;
        if (ovf_w !== 1'b0) $display("FAIL resume_ovf: got %b expected %b", ovf_w, 1'b0);
        else pass_cnt++;
        idle_ctrl();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_wrap();
        test_saturate();
        test_shifts();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
